sram_mem_controller: RTL

Multi-cycle controller that sequences 32-bit MEM-stage load/store requests onto an external 16-bit asynchronous SRAM. Each word is split into two half-word accesses with programmable wait states. A `ready` signal freezes the pipeline while an access is in flight. It sits between the MEM stage (request side) and the SRAM pins, and replaces the single-cycle data memory.

---
 rtl/sram_mem_controller_pkg.sv | 9 +
 rtl/sram_mem_controller_if.sv | 22 ++
 rtl/sram_mem_controller_wait_counter.sv | 17 +
 rtl/sram_mem_controller.sv | 87 ++++++++
 4 files changed

// File: rtl/sram_mem_controller_pkg.sv
// sram_mem_controller_pkg: shared state encoding, defaults and address helper
package sram_mem_controller_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam int CNT_W = 4;
  function automatic logic [31:0] word_off(input logic [31:0] a, input logic [31:0] base);
    return (a - base) >> 2;
  endfunction
endpackage

// File: rtl/sram_mem_controller_if.sv
// sram_mem_controller_if: MEM-stage request bus plus SRAM pin bundle
interface sram_mem_controller_if #(parameter int SRAM_AW = 18);
  logic rd_en;
  logic wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic sram_dq_oe;
  logic sram_we_n;
  modport slave (
    input rd_en, wr_en, addr, wr_data, sram_dq_in,
    output rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
  modport master (
    output rd_en, wr_en, addr, wr_data, sram_dq_in,
    input rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller_wait_counter.sv
// sram_wait_counter: per-half-word wait-state counter with terminal flag
module sram_wait_counter
  import sram_mem_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  assign last = cnt == CNT_W'(WAIT_CYCLES - 1);
endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: sequences 32-bit loads/stores as two 16-bit async SRAM accesses
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  sram_mem_controller_if.slave bus
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic last, hold, busy, req;
  logic is_write, is_write_nx, oe_nx, we_n_nx;
  logic [15:0] wr_hi, wr_hi_nx, dq_nx;
  logic [31:0] rd_nx;
  logic [SRAM_AW-1:0] addr_nx, lo_addr;
  assign req = bus.rd_en | bus.wr_en;
  assign busy = state == LOW || state == HIGH;
  assign hold = cnt == CNT_W'(WAIT_CYCLES - 2);
  assign lo_addr = {(SRAM_AW-1)'(word_off(bus.addr, BASE_ADDR)), 1'b0};
  assign bus.ready = (state == IDLE && !req) || state == DONE;
  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(!busy || last),
    .cnt(cnt),
    .last(last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // DONE always returns to IDLE so a request still held from the finished instruction is not re-issued
  always_comb
    state_nx = state == IDLE ? (req ? LOW : IDLE) :
               state == LOW  ? (last ? HIGH : LOW) :
               state == HIGH ? (last ? DONE : HIGH) : IDLE;
  always_comb begin
    addr_nx = bus.sram_addr;
    dq_nx = bus.sram_dq_out;
    oe_nx = bus.sram_dq_oe;
    we_n_nx = bus.sram_we_n;
    rd_nx = bus.rd_data;
    is_write_nx = is_write;
    wr_hi_nx = wr_hi;
    if (state == IDLE && req) begin
      is_write_nx = bus.wr_en;
      wr_hi_nx = bus.wr_data[31:16];
      addr_nx = lo_addr;
      dq_nx = bus.wr_data[15:0];
      oe_nx = bus.wr_en;
      we_n_nx = !bus.wr_en;
    end else if (busy && last && state == LOW) begin
      rd_nx[15:0] = is_write ? bus.rd_data[15:0] : bus.sram_dq_in;
      addr_nx[0] = 1'b1;
      dq_nx = wr_hi;
      we_n_nx = !is_write;
    end else if (busy && last) begin
      rd_nx[31:16] = is_write ? bus.rd_data[31:16] : bus.sram_dq_in;
      oe_nx = 1'b0;
      we_n_nx = 1'b1;
    end else if (busy && hold) begin
      we_n_nx = 1'b1;
    end
  end
  // strobe rises one cycle before address/data move, giving a write-hold cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.sram_addr <= '0;
      bus.sram_dq_out <= '0;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_we_n <= 1'b1;
      bus.rd_data <= '0;
      is_write <= 1'b0;
      wr_hi <= '0;
    end else begin
      bus.sram_addr <= addr_nx;
      bus.sram_dq_out <= dq_nx;
      bus.sram_dq_oe <= oe_nx;
      bus.sram_we_n <= we_n_nx;
      bus.rd_data <= rd_nx;
      is_write <= is_write_nx;
      wr_hi <= wr_hi_nx;
    end
endmodule
